uart_cmd_parser: RTL and testbench

Byte-stream command decoder sitting directly downstream of the UART receiver. Consumes one received byte per `uart_ready` pulse, frames fixed-length 8-byte packets (sync, opcode, 24-bit address, 16-bit data, XOR checksum), and presents validated commands to the SDRAM/TFT control logic over a valid/ready handshake. Malformed, stalled or overflowing packets are dropped and flagged with single-cycle error pulses.

---
 rtl/uart_cmd_pkg.sv | 24 ++
 rtl/uart_cmd_parser_if.sv | 13 +
 rtl/uart_cmd_timer.sv | 33 +++
 rtl/uart_cmd_parser.sv | 121 ++++++++++++
 tb/tb_uart_cmd_parser.sv | 193 +++++++++++++++++++
 5 files changed

// File: rtl/uart_cmd_pkg.sv
// Shared constants, FSM encoding and checksum/opcode helpers for the UART
// command parser.
package uart_cmd_pkg;

  localparam logic [7:0] SYNC_BYTE_DEF = 8'h55;
  localparam logic [7:0] OP_SD_WR      = 8'h01;
  localparam logic [7:0] OP_SD_RD      = 8'h02;
  localparam logic [7:0] OP_TFT_WR     = 8'h03;
  localparam int         PKT_LEN       = 8;
  localparam int         STATE_W       = $clog2(PKT_LEN);

  typedef enum logic [STATE_W-1:0] {
    S_HUNT, S_OP, S_A2, S_A1, S_A0, S_D1, S_D0, S_CHK
  } state_e;

  function automatic logic op_known(input logic [7:0] op);
    return (op == OP_SD_WR) || (op == OP_SD_RD) || (op == OP_TFT_WR);
  endfunction

  function automatic logic [7:0] chk_step(input logic [7:0] acc, input logic [7:0] b);
    return acc ^ b;
  endfunction

endpackage

// File: rtl/uart_cmd_parser_if.sv
// Command channel from the parser to the SDRAM/TFT control logic.
interface uart_cmd_parser_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [7:0]  cmd_op;
  logic [23:0] cmd_addr;
  logic [15:0] cmd_data;

  modport master (output cmd_valid, output cmd_op, output cmd_addr, output cmd_data,
                  input cmd_ready);
  modport slave  (input cmd_valid, input cmd_op, input cmd_addr, input cmd_data,
                  output cmd_ready);
endinterface

// File: rtl/uart_cmd_timer.sv
// Inter-byte timeout counter; expire is a single-cycle strobe that also
// clears the count, so the counter never wraps.
module uart_cmd_timer #(
  parameter int CYCLES = 2000
) (
  input  logic sys_clk,
  input  logic sys_rst,
  input  logic clr,
  input  logic en,
  output logic expire
);

  localparam int           W    = $clog2(CYCLES);
  localparam logic [W-1:0] LAST = W'(CYCLES - 1);

  logic [W-1:0] cnt_r;

  assign expire = en && !clr && (cnt_r == LAST);

  // Count idle cycles while a packet is in flight.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      cnt_r <= '0;
    end else if (clr || expire) begin
      cnt_r <= '0;
    end else if (en) begin
      cnt_r <= cnt_r + W'(1);
    end else begin
      cnt_r <= cnt_r;
    end
  end

endmodule

// File: rtl/uart_cmd_parser.sv
// Frames 8-byte UART command packets, validates checksum and opcode, and
// hands accepted commands to a single-entry valid/ready output register.
module uart_cmd_parser
  import uart_cmd_pkg::*;
#(
  parameter int         TIMEOUT_CYCLES = 2000,
  parameter logic [7:0] SYNC_BYTE      = SYNC_BYTE_DEF
) (
  input  logic                      sys_clk,
  input  logic                      sys_rst,
  input  logic [7:0]                uart_data_rx,
  input  logic                      uart_ready,
  uart_cmd_parser_if.master         cmd,
  output logic                      err_chk,
  output logic                      err_op,
  output logic                      err_timeout,
  output logic                      err_ovf
);

  state_e      state_r;
  logic [7:0]  chk_r;
  logic [7:0]  op_r;
  logic [23:0] addr_r;
  logic [15:0] data_r;
  logic        tmo_clr_s;
  logic        tmo_en_s;
  logic        tmo_expire_s;

  assign tmo_en_s  = (state_r != S_HUNT);
  assign tmo_clr_s = uart_ready || (state_r == S_HUNT);

  uart_cmd_timer #(.CYCLES(TIMEOUT_CYCLES)) u_timer (
    .sys_clk (sys_clk),
    .sys_rst (sys_rst),
    .clr     (tmo_clr_s),
    .en      (tmo_en_s),
    .expire  (tmo_expire_s)
  );

  // Packet FSM, field capture, checksum and output register.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_r       <= S_HUNT;
      chk_r         <= 8'h00;
      op_r          <= 8'h00;
      addr_r        <= 24'h000000;
      data_r        <= 16'h0000;
      cmd.cmd_valid <= 1'b0;
      cmd.cmd_op    <= 8'h00;
      cmd.cmd_addr  <= 24'h000000;
      cmd.cmd_data  <= 16'h0000;
      err_chk       <= 1'b0;
      err_op        <= 1'b0;
      err_timeout   <= 1'b0;
      err_ovf       <= 1'b0;
    end else begin
      err_chk     <= 1'b0;
      err_op      <= 1'b0;
      err_timeout <= 1'b0;
      err_ovf     <= 1'b0;
      if (cmd.cmd_valid && cmd.cmd_ready) begin
        cmd.cmd_valid <= 1'b0;
      end else begin
        cmd.cmd_valid <= cmd.cmd_valid;
      end

      // A byte arriving in the expiry cycle takes precedence over the timeout.
      if (uart_ready) begin
        case (state_r)
          S_HUNT: begin
            if (uart_data_rx == SYNC_BYTE) begin
              state_r <= S_OP;
              chk_r   <= 8'h00;
            end else begin
              state_r <= S_HUNT;
            end
          end
          S_OP: begin
            op_r    <= uart_data_rx;
            chk_r   <= chk_step(chk_r, uart_data_rx);
            state_r <= S_A2;
          end
          S_A2, S_A1, S_A0: begin
            addr_r  <= {addr_r[15:0], uart_data_rx};
            chk_r   <= chk_step(chk_r, uart_data_rx);
            state_r <= (state_r == S_A2) ? S_A1 : (state_r == S_A1) ? S_A0 : S_D1;
          end
          S_D1, S_D0: begin
            data_r  <= {data_r[7:0], uart_data_rx};
            chk_r   <= chk_step(chk_r, uart_data_rx);
            state_r <= (state_r == S_D1) ? S_D0 : S_CHK;
          end
          S_CHK: begin
            state_r <= S_HUNT;
            if (uart_data_rx != chk_r) begin
              err_chk <= 1'b1;
            end else if (!op_known(op_r)) begin
              err_op <= 1'b1;
            end else if (cmd.cmd_valid && !cmd.cmd_ready) begin
              err_ovf <= 1'b1;
            end else begin
              cmd.cmd_valid <= 1'b1;
              cmd.cmd_op    <= op_r;
              cmd.cmd_addr  <= addr_r;
              cmd.cmd_data  <= data_r;
            end
          end
          default: begin
            state_r <= S_HUNT;
          end
        endcase
      end else if (tmo_expire_s) begin
        state_r     <= S_HUNT;
        err_timeout <= 1'b1;
      end else begin
        state_r <= state_r;
      end
    end
  end

endmodule

// File: tb/tb_uart_cmd_parser.sv
// Directed, table-driven bench for uart_cmd_parser plus hand-written
// sequences for overflow, timeout and mid-packet reset.
module tb_uart_cmd_parser;

  localparam int TMO = 2000;

  logic       sys_clk = 1'b0;
  logic       sys_rst = 1'b1;
  logic [7:0] uart_data_rx = 8'h00;
  logic       uart_ready = 1'b0;
  logic       err_chk, err_op, err_timeout, err_ovf;

  int checks   = 0;
  int failures = 0;

  uart_cmd_parser_if cmd_bus ();

  uart_cmd_parser #(.TIMEOUT_CYCLES(TMO), .SYNC_BYTE(8'h55)) dut (
    .sys_clk      (sys_clk),
    .sys_rst      (sys_rst),
    .uart_data_rx (uart_data_rx),
    .uart_ready   (uart_ready),
    .cmd          (cmd_bus),
    .err_chk      (err_chk),
    .err_op       (err_op),
    .err_timeout  (err_timeout),
    .err_ovf      (err_ovf)
  );

  always #5 sys_clk = ~sys_clk;

  typedef struct {
    logic [63:0] pkt;
    logic        exp_valid;
    logic [7:0]  exp_op;
    logic [23:0] exp_addr;
    logic [15:0] exp_data;
    logic [3:0]  exp_err;   // {chk, op, timeout, ovf}
  } vec_t;

  vec_t vecs[9];

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  function automatic logic [3:0] errs();
    return {err_chk, err_op, err_timeout, err_ovf};
  endfunction

  // Each byte is one uart_ready pulse followed by an idle cycle; returns at the
  // negedge just after the consuming posedge.
  task automatic send_byte(input logic [7:0] b, input logic rdy_with_byte, input logic set_rdy);
    @(negedge sys_clk);
    uart_ready   = 1'b1;
    uart_data_rx = b;
    if (set_rdy) cmd_bus.cmd_ready = rdy_with_byte;
    @(negedge sys_clk);
    uart_ready = 1'b0;
  endtask

  task automatic send_pkt(input logic [63:0] p);
    for (int i = 0; i < 8; i++) send_byte(p[63-8*i -: 8], 1'b0, 1'b0);
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_valid"}, {63'd0, cmd_bus.cmd_valid}, 64'd0);
    check({tag, "_op"},    {56'd0, cmd_bus.cmd_op},    64'd0);
    check({tag, "_addr"},  {40'd0, cmd_bus.cmd_addr},  64'd0);
    check({tag, "_data"},  {48'd0, cmd_bus.cmd_data},  64'd0);
    check({tag, "_err"},   {60'd0, errs()},            64'd0);
  endtask

  initial begin
    int pulses;
    int pulse_at;

    // pkt, valid, op, addr, data, errs
    vecs[0] = '{64'h55_01_12_34_56_AB_CD_17, 1'b1, 8'h01, 24'h123456, 16'hABCD, 4'b0000};
    vecs[1] = '{64'h55_01_12_34_56_AB_CD_10, 1'b0, 8'h00, 24'h000000, 16'h0000, 4'b1000};
    vecs[2] = '{64'h55_01_12_34_56_AB_CD_17, 1'b1, 8'h01, 24'h123456, 16'hABCD, 4'b0000};
    vecs[3] = '{64'h55_07_12_34_56_AB_CD_11, 1'b0, 8'h00, 24'h000000, 16'h0000, 4'b0100};
    vecs[4] = '{64'h55_07_12_34_56_AB_CD_17, 1'b0, 8'h00, 24'h000000, 16'h0000, 4'b1000};
    vecs[5] = '{64'h55_02_00_00_10_00_00_12, 1'b1, 8'h02, 24'h000010, 16'h0000, 4'b0000};
    vecs[6] = '{64'h55_03_AB_CD_EF_12_34_AC, 1'b1, 8'h03, 24'hABCDEF, 16'h1234, 4'b0000};
    vecs[7] = '{64'h55_01_55_55_55_55_55_54, 1'b1, 8'h01, 24'h555555, 16'h5555, 4'b0000};
    vecs[8] = '{64'h55_00_00_00_00_00_00_00, 1'b0, 8'h00, 24'h000000, 16'h0000, 4'b0100};

    cmd_bus.cmd_ready = 1'b1;
    repeat (3) @(negedge sys_clk);
    sys_rst = 1'b0;
    check_idle_outputs("reset");

    for (int v = 0; v < 9; v++) begin
      send_pkt(vecs[v].pkt);
      check($sformatf("vec%0d_valid", v), {63'd0, cmd_bus.cmd_valid}, {63'd0, vecs[v].exp_valid});
      check($sformatf("vec%0d_err", v), {60'd0, errs()}, {60'd0, vecs[v].exp_err});
      if (vecs[v].exp_valid) begin
        check($sformatf("vec%0d_op", v),   {56'd0, cmd_bus.cmd_op},   {56'd0, vecs[v].exp_op});
        check($sformatf("vec%0d_addr", v), {40'd0, cmd_bus.cmd_addr}, {40'd0, vecs[v].exp_addr});
        check($sformatf("vec%0d_data", v), {48'd0, cmd_bus.cmd_data}, {48'd0, vecs[v].exp_data});
      end
      @(negedge sys_clk);
      check($sformatf("vec%0d_valid_drop", v), {63'd0, cmd_bus.cmd_valid}, 64'd0);
      check($sformatf("vec%0d_err_drop", v), {60'd0, errs()}, 64'd0);
    end

    // Output occupied: second good packet is dropped, first held stable.
    cmd_bus.cmd_ready = 1'b0;
    send_pkt(vecs[0].pkt);
    check("ovf_first_valid", {63'd0, cmd_bus.cmd_valid}, 64'd1);
    send_pkt(vecs[6].pkt);
    check("ovf_err",   {60'd0, errs()}, 64'b0001);
    check("ovf_valid", {63'd0, cmd_bus.cmd_valid}, 64'd1);
    check("ovf_op",    {56'd0, cmd_bus.cmd_op},   64'h01);
    check("ovf_addr",  {40'd0, cmd_bus.cmd_addr}, 64'h123456);
    check("ovf_data",  {48'd0, cmd_bus.cmd_data}, 64'hABCD);
    cmd_bus.cmd_ready = 1'b1;
    @(negedge sys_clk);
    check("ovf_drain", {63'd0, cmd_bus.cmd_valid}, 64'd0);

    // Transfer in the completion cycle: second packet loads without error.
    cmd_bus.cmd_ready = 1'b0;
    send_pkt(vecs[0].pkt);
    for (int i = 0; i < 7; i++) send_byte(vecs[6].pkt[63-8*i -: 8], 1'b0, 1'b0);
    send_byte(vecs[6].pkt[7:0], 1'b1, 1'b1);
    cmd_bus.cmd_ready = 1'b0;
    check("swap_err",   {60'd0, errs()}, 64'd0);
    check("swap_valid", {63'd0, cmd_bus.cmd_valid}, 64'd1);
    check("swap_op",    {56'd0, cmd_bus.cmd_op},   64'h03);
    check("swap_addr",  {40'd0, cmd_bus.cmd_addr}, 64'hABCDEF);
    check("swap_data",  {48'd0, cmd_bus.cmd_data}, 64'h1234);
    cmd_bus.cmd_ready = 1'b1;
    @(negedge sys_clk);

    // Stall after three bytes: exactly one timeout pulse, TMO cycles later.
    send_byte(8'h55, 1'b0, 1'b0);
    send_byte(8'h01, 1'b0, 1'b0);
    send_byte(8'h12, 1'b0, 1'b0);
    pulses   = 0;
    pulse_at = 0;
    for (int k = 1; k <= TMO + 100; k++) begin
      if (k > 1) @(negedge sys_clk);
      else @(negedge sys_clk);
      if (err_timeout) begin
        pulses++;
        pulse_at = k;
      end
    end
    check("tmo_pulses", pulses, 1);
    check("tmo_cycle",  pulse_at, TMO);
    check("tmo_valid",  {63'd0, cmd_bus.cmd_valid}, 64'd0);
    send_byte(8'h00, 1'b0, 1'b0);
    send_byte(8'hFF, 1'b0, 1'b0);
    check("junk_err", {60'd0, errs()}, 64'd0);
    send_pkt(vecs[5].pkt);
    check("post_tmo_valid", {63'd0, cmd_bus.cmd_valid}, 64'd1);
    check("post_tmo_addr",  {40'd0, cmd_bus.cmd_addr},  64'h000010);
    @(negedge sys_clk);

    // Reset mid-packet with a held command: everything clears silently.
    cmd_bus.cmd_ready = 1'b0;
    send_pkt(vecs[6].pkt);
    send_byte(8'h55, 1'b0, 1'b0);
    send_byte(8'h01, 1'b0, 1'b0);
    send_byte(8'h12, 1'b0, 1'b0);
    send_byte(8'h34, 1'b0, 1'b0);
    sys_rst = 1'b1;
    @(negedge sys_clk);
    sys_rst = 1'b0;
    check_idle_outputs("mid_rst");
    pulses = 0;
    for (int k = 0; k < TMO + 50; k++) begin
      @(negedge sys_clk);
      if (errs() != 4'b0000) pulses++;
    end
    check("mid_rst_no_err", pulses, 0);
    cmd_bus.cmd_ready = 1'b1;
    send_pkt(vecs[0].pkt);
    check("post_rst_valid", {63'd0, cmd_bus.cmd_valid}, 64'd1);
    check("post_rst_op",    {56'd0, cmd_bus.cmd_op},   64'h01);
    check("post_rst_addr",  {40'd0, cmd_bus.cmd_addr}, 64'h123456);
    check("post_rst_data",  {48'd0, cmd_bus.cmd_data}, 64'hABCD);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
